// File: rtl/instr_fetch_queue_if.sv
// Bundle of the instruction-memory request port, the decode-side instruction
// stream and the redirect inputs of the fetch front-end.
interface instr_fetch_queue_if;
  // Handshakes: memory side is req/ack. im_req stays high and im_addr stays stable
  // until the cycle in which im_ack is seen; the word on im_rdata is taken in that
  // same cycle. Decode side is valid/ready. ir_valid does not depend on ir_ready,
  // and the head entry is popped on any rising edge where ir_valid && ir_ready.
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_out;
  logic [31:0] pc_out;
  logic [31:0] se_16;
  logic        redirect;
  logic [1:0]  redir_sel;
  logic [31:0] pc_in;
  logic [31:0] pc_jr;
  logic        misalign;
  logic [1:0]  fsm_state;

  modport master (
    output im_req, im_addr, ir_valid, ir_out, pc_out, se_16, misalign, fsm_state,
    input  im_ack, im_rdata, ir_ready, redirect, redir_sel, pc_in, pc_jr
  );

  modport slave (
    input  im_req, im_addr, ir_valid, ir_out, pc_out, se_16, misalign, fsm_state,
    output im_ack, im_rdata, ir_ready, redirect, redir_sel, pc_in, pc_jr
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: owns the fetch PC, issues one outstanding memory request at a
// time, and buffers fetched words with their PCs in a small prefetch FIFO.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          IMEM_AW  = 12,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_queue_if.master bus
);
  localparam int         PW      = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [31:0]        fpc_q, fpc_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [PW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]        cnt_q, cnt_d;
  logic               mis_q, mis_d;

  logic [31:0] mem_ir [DEPTH];
  logic [31:0] mem_pc [DEPTH];

  logic [31:0] head_ir, head_pc, se16, pch, raw_tgt;
  logic [PW:0] occ_after_pop;
  logic        pop, push;

  assign head_ir = mem_ir[rd_q];
  assign head_pc = mem_pc[rd_q];
  assign se16    = {{16{head_ir[15]}}, head_ir[15:0]};
  assign pch     = head_pc + 32'd4;

  always_comb begin
    raw_tgt = bus.pc_jr;
    case (bus.redir_sel)
      2'b00:   raw_tgt = pch + {se16[29:0], 2'b00};
      2'b01:   raw_tgt = {pch[31:28], head_ir[25:0], 2'b00};
      2'b10:   raw_tgt = bus.pc_in;
      default: raw_tgt = bus.pc_jr;
    endcase
  end

  // A redirect wins over everything that would touch the FIFO this cycle.
  assign push          = (state_q == ST_REQ) && bus.im_ack && !bus.redirect;
  assign pop           = (cnt_q != '0) && bus.ir_ready && !bus.redirect;
  assign occ_after_pop = cnt_q - (PW+1)'(pop);

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    mis_d   = bus.redirect && (raw_tgt[1:0] != 2'b00);

    case (state_q)
      ST_IDLE: begin
        if (!bus.redirect && (occ_after_pop < DEPTH_C)) begin
          state_d = ST_REQ;
          addr_d  = fpc_q[IMEM_AW-1:0];
        end
      end
      ST_REQ: begin
        if (bus.im_ack) begin
          state_d = ST_IDLE;
          if (!bus.redirect) fpc_d = fpc_q + 32'd4;
        end else if (bus.redirect) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        // The abandoned request must still finish its handshake; its data is ignored.
        if (bus.im_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.redirect) begin
      fpc_d = {raw_tgt[31:2], 2'b00};
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (pop)  rd_d = rd_q + 1'b1;
      if (push) wr_d = wr_q + 1'b1;
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fpc_q   <= RESET_PC;
      addr_q  <= RESET_PC[IMEM_AW-1:0];
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ir[wr_q] <= bus.im_rdata;
      mem_pc[wr_q] <= fpc_q;
    end
  end

  assign bus.im_req    = (state_q == ST_REQ) || (state_q == ST_DROP);
  assign bus.im_addr   = {{(32-IMEM_AW){1'b0}}, addr_q};
  assign bus.ir_valid  = (cnt_q != '0);
  assign bus.ir_out    = head_ir;
  assign bus.pc_out    = head_pc;
  assign bus.se_16     = se16;
  assign bus.misalign  = mis_q;
  assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus a random
// phase, all compared against a queue-based behavioural model of the fetch unit.
module tb_instr_fetch_queue;
  localparam int DEPTH   = 4;
  localparam int IMEM_AW = 12;
  localparam logic [31:0] AMASK = 32'((64'd1 << IMEM_AW) - 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_queue_if bus ();
  instr_fetch_queue_if wbus ();

  instr_fetch_queue #(.DEPTH(DEPTH), .IMEM_AW(IMEM_AW), .RESET_PC(32'h0)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  instr_fetch_queue #(.DEPTH(DEPTH), .IMEM_AW(IMEM_AW), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (wbus.master)
  );

  // Second instance just streams from its reset PC to exercise 32-bit wrap.
  assign wbus.im_ack    = wbus.im_req;
  assign wbus.im_rdata  = 32'hA5A5_0000 ^ wbus.im_addr;
  assign wbus.ir_ready  = 1'b1;
  assign wbus.redirect  = 1'b0;
  assign wbus.redir_sel = 2'b10;
  assign wbus.pc_in     = 32'h0;
  assign wbus.pc_jr     = 32'h0;

  logic [31:0] w_pc_q[$];
  logic [31:0] w_addr_q[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (wbus.ir_valid && w_pc_q.size() < 4) w_pc_q.push_back(wbus.pc_out);
      if (wbus.im_req && w_addr_q.size() < 3) w_addr_q.push_back(wbus.im_addr);
    end
  end

  // Reference model: {pc, word} entries in order, plus the fetch-side bookkeeping.
  logic [63:0] exp_q[$];
  logic [31:0] m_fpc, m_addr;
  bit          m_req, m_drop, m_mis;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [63:0] head;
    logic [31:0] pch, tgt;
    bit          has, pop, nxt_mis;
    int          s;
    #1;
    has  = (exp_q.size() != 0);
    head = has ? exp_q[0] : 64'h0;
    chk("ir_valid", 32'(bus.ir_valid), 32'(has));
    if (has) begin
      s = $signed(head[15:0]);
      chk("pc_out", bus.pc_out, head[63:32]);
      chk("ir_out", bus.ir_out, head[31:0]);
      chk("se_16", bus.se_16, 32'(s));
    end
    chk("im_req", 32'(bus.im_req), 32'(m_req));
    if (m_req) chk("im_addr", bus.im_addr, m_addr & AMASK);
    chk("misalign", 32'(bus.misalign), 32'(m_mis));

    pop     = has && bus.ir_ready && !bus.redirect;
    nxt_mis = 1'b0;
    if (bus.redirect) begin
      pch = head[63:32] + 32'd4;
      case (bus.redir_sel)
        2'd0: begin s = $signed(head[15:0]); tgt = pch + 32'(s * 4); end
        2'd1: tgt = (pch & 32'hF000_0000) | ((head[31:0] & 32'h03FF_FFFF) << 2);
        2'd2: tgt = bus.pc_in;
        default: tgt = bus.pc_jr;
      endcase
      nxt_mis = (tgt % 4) != 0;
      m_fpc   = tgt - (tgt % 4);
      exp_q.delete();
      if (m_req) begin
        if (bus.im_ack) begin m_req = 0; m_drop = 0; end
        else m_drop = 1;
      end
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (m_req) begin
        if (bus.im_ack) begin
          if (!m_drop) begin
            exp_q.push_back({m_fpc, bus.im_rdata});
            m_fpc += 32'd4;
          end
          m_req  = 0;
          m_drop = 0;
        end
      end else if (exp_q.size() < DEPTH) begin
        m_req  = 1;
        m_addr = m_fpc;
      end
    end
    m_mis = nxt_mis;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Fetch exactly one word into an empty queue with decode stalled.
  task automatic fetch_one(input logic [31:0] data);
    int n = 0;
    bus.ir_ready = 1'b0;
    bus.redirect = 1'b0;
    while (exp_q.size() == 0 && n < 20) begin
      bus.im_ack   = m_req;
      bus.im_rdata = data;
      tick();
      n++;
    end
    bus.im_ack = 1'b0;
    if (n >= 20) chk("fetch_timeout", 32'(exp_q.size()), 32'd1);
  endtask

  task automatic do_redirect(input logic [1:0] sel, input logic [31:0] pin, input logic [31:0] pjr);
    bus.redirect  = 1'b1;
    bus.redir_sel = sel;
    bus.pc_in     = pin;
    bus.pc_jr     = pjr;
    tick();
    bus.redirect  = 1'b0;
  endtask

  initial begin
    int k, n;
    reset         = 1'b1;
    bus.im_ack    = 1'b0;
    bus.im_rdata  = 32'h0;
    bus.ir_ready  = 1'b0;
    bus.redirect  = 1'b0;
    bus.redir_sel = 2'b10;
    bus.pc_in     = 32'h0;
    bus.pc_jr     = 32'h0;
    exp_q.delete();
    m_fpc = 32'h0; m_addr = 32'h0; m_req = 0; m_drop = 0; m_mis = 0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
    chk("rst_im_req", 32'(bus.im_req), 32'd0);
    chk("rst_misalign", 32'(bus.misalign), 32'd0);
    reset = 1'b0;

    // Streaming with same-cycle ack and decode always ready.
    k = 0;
    bus.ir_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bus.im_ack   = m_req;
      bus.im_rdata = $urandom();
      if (exp_q.size() != 0 && k < 4) begin
        #1 chk("stream_pc", bus.pc_out, 32'(k * 4));
        k++;
      end
      tick();
    end

    // Stalled decode: acks offered on every request, FIFO must stop at DEPTH.
    bus.ir_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.im_ack   = m_req;
      bus.im_rdata = $urandom();
      tick();
    end
    #1 chk("full_no_req", 32'(bus.im_req), 32'd0);
    chk("full_valid", 32'(bus.ir_valid), 32'd1);
    bus.ir_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.im_ack   = m_req;
      bus.im_rdata = $urandom();
      tick();
    end

    // Redirect while a request is outstanding; its late ack must be discarded.
    bus.im_ack = 1'b0;
    n = 0;
    while (!m_req && n < 10) begin tick(); n++; end
    do_redirect(2'b10, 32'h0000_0100, 32'h0);
    tick();
    tick();
    bus.im_ack   = 1'b1;
    bus.im_rdata = 32'hDEAD_BEEF;
    tick();
    bus.im_ack = 1'b0;
    n = 0;
    while (!m_req && n < 10) begin tick(); n++; end
    #1 chk("redir_addr", bus.im_addr, 32'h0000_0100);

    // Jump and branch targets computed from the head entry.
    do_redirect(2'b10, 32'h2000_0010, 32'h0);
    fetch_one(32'h0800_0040);
    #1 chk("head_pc_j", bus.pc_out, 32'h2000_0010);
    do_redirect(2'b01, 32'h0, 32'h0);
    fetch_one($urandom());
    #1 chk("jump_target", bus.pc_out, 32'h2000_0100);

    do_redirect(2'b10, 32'h2000_0010, 32'h0);
    fetch_one(32'h1234_FFFE);
    #1 chk("head_se16", bus.se_16, 32'hFFFF_FFFE);
    do_redirect(2'b00, 32'h0, 32'h0);
    fetch_one($urandom());
    #1 chk("branch_target", bus.pc_out, 32'h2000_000C);

    // Misaligned register target.
    do_redirect(2'b11, 32'h0, 32'h0000_0203);
    #1 chk("misalign_pulse", 32'(bus.misalign), 32'd1);
    tick();
    #1 chk("misalign_clear", 32'(bus.misalign), 32'd0);
    fetch_one($urandom());
    #1 chk("jr_target", bus.pc_out, 32'h0000_0200);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.ir_ready  = ($urandom_range(0, 3) != 0);
      bus.im_ack    = m_req && ($urandom_range(0, 1) == 1);
      bus.im_rdata  = $urandom();
      bus.redirect  = ($urandom_range(0, 19) == 0);
      bus.redir_sel = 2'($urandom_range(0, 3));
      if (bus.redir_sel[1] == 1'b0 && exp_q.size() == 0) bus.redir_sel = 2'b10;
      bus.pc_in     = $urandom() & ($urandom_range(0, 1) == 1 ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      bus.pc_jr     = $urandom();
      tick();
    end
    bus.redirect = 1'b0;
    bus.im_ack   = 1'b0;

    // Wrap-around instance.
    chk("wrap_pc_count", 32'(w_pc_q.size()), 32'd4);
    if (w_pc_q.size() == 4) begin
      chk("wrap_pc0", w_pc_q[0], 32'hFFFF_FFF8);
      chk("wrap_pc1", w_pc_q[1], 32'hFFFF_FFFC);
      chk("wrap_pc2", w_pc_q[2], 32'h0000_0000);
      chk("wrap_pc3", w_pc_q[3], 32'h0000_0004);
    end
    chk("wrap_addr_count", 32'(w_addr_q.size()), 32'd3);
    if (w_addr_q.size() == 3) begin
      chk("wrap_addr0", w_addr_q[0], 32'hFFFF_FFF8 & AMASK);
      chk("wrap_addr1", w_addr_q[1], 32'hFFFF_FFFC & AMASK);
      chk("wrap_addr2", w_addr_q[2], 32'h0000_0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
